// File: rtl/guess_entry.sv
`default_nettype none
// ============================================================================
// Module      : guess_entry
// Description : Gathers key events into a 3-digit guess, checks it, and
//               issues it to the game controller.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_entry #(
    parameter int ERR_CYCLES       = 25_000_000,
    parameter bit REQUIRE_DISTINCT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic       num_rdy,
    output logic [3:0] ent1,
    output logic [3:0] ent2,
    output logic [3:0] ent3,
    output logic [1:0] entry_cnt,
    output logic       err,
    output logic [7:0] guess_cnt
);

    localparam logic [1:0] S_ENTRY = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [4:0] KEY_ENTER = 5'h10;
    localparam logic [4:0] KEY_BKSP  = 5'h11;
    localparam logic [4:0] KEY_CLEAR = 5'h12;

    localparam int             TW       = $clog2(ERR_CYCLES + 1);
    localparam logic [TW-1:0]  TMR_LAST = TW'(ERR_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    ent_q [3];
    logic [3:0]    ent_d [3];
    logic [3:0]    num_q [3];
    logic [3:0]    num_d [3];
    logic [1:0]    cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;
    logic [7:0]    gcnt_q, gcnt_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic w_is_digit;
    logic w_dup;

    assign w_is_digit = (key_code <= 5'd9);
    assign w_dup      = (ent_q[0] == ent_q[1]) | (ent_q[0] == ent_q[2]) |
                        (ent_q[1] == ent_q[2]);

    always_comb begin
        state_d = state_q;
        ent_d   = ent_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        tmr_d   = tmr_q;

        case (state_q)
            S_ENTRY: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        if (cnt_q != 2'd3) begin
                            for (int i = 0; i < 3; i++) begin
                                if (cnt_q == 2'(i)) ent_d[i] = key_code[3:0];
                            end
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else if (key_code == KEY_BKSP) begin
                        if (cnt_q != 2'd0) begin
                            for (int i = 0; i < 3; i++) begin
                                if (cnt_q == 2'(i + 1)) ent_d[i] = 4'd0;
                            end
                            cnt_d = cnt_q - 2'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        for (int i = 0; i < 3; i++) ent_d[i] = 4'd0;
                        cnt_d = 2'd0;
                    end else if (key_code == KEY_ENTER) begin
                        tmr_d   = '0;
                        state_d = (cnt_q == 2'd3) ? S_CHECK : S_ERROR;
                    end
                end
            end
            S_CHECK: begin
                if (REQUIRE_DISTINCT && w_dup) begin
                    tmr_d   = '0;
                    state_d = S_ERROR;
                end else begin
                    // Commit happens on entry to ISSUE so num_rdy and num1..3 line up
                    num_d = ent_q;
                    for (int i = 0; i < 3; i++) ent_d[i] = 4'd0;
                    cnt_d = 2'd0;
                    if (gcnt_q != 8'hFF) gcnt_d = gcnt_q + 8'd1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_ENTRY;
            end
            default: begin
                if (tmr_q == TMR_LAST) begin
                    tmr_d   = '0;
                    state_d = S_ENTRY;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
        endcase

        rdy_d = (state_d == S_ISSUE);
        err_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ENTRY;
            for (int i = 0; i < 3; i++) begin
                ent_q[i] <= 4'd0;
                num_q[i] <= 4'd0;
            end
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            gcnt_q <= 8'd0;
            tmr_q  <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            gcnt_q  <= gcnt_d;
            tmr_q   <= tmr_d;
        end
    end

    assign num1      = num_q[0];
    assign num2      = num_q[1];
    assign num3      = num_q[2];
    assign num_rdy   = rdy_q;
    assign ent1      = ent_q[0];
    assign ent2      = ent_q[1];
    assign ent3      = ent_q[2];
    assign entry_cnt = cnt_q;
    assign err       = err_q;
    assign guess_cnt = gcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_guess_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_entry
// Description : Self-checking bench for guess_entry (distinct and non-distinct).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_entry;

    localparam int ERR = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [4:0] key_code = 5'd0;

    logic [3:0] d_n1, d_n2, d_n3, d_e1, d_e2, d_e3;
    logic [3:0] n_n1, n_n2, n_n3, n_e1, n_e2, n_e3;
    logic       d_rdy, d_err, n_rdy, n_err;
    logic [1:0] d_cnt, n_cnt;
    logic [7:0] d_gc, n_gc;

    always #5 clk = ~clk;

    guess_entry #(.ERR_CYCLES(ERR), .REQUIRE_DISTINCT(1'b1)) dut_d (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .num1(d_n1), .num2(d_n2), .num3(d_n3), .num_rdy(d_rdy),
        .ent1(d_e1), .ent2(d_e2), .ent3(d_e3), .entry_cnt(d_cnt),
        .err(d_err), .guess_cnt(d_gc)
    );

    guess_entry #(.ERR_CYCLES(ERR), .REQUIRE_DISTINCT(1'b0)) dut_n (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .num1(n_n1), .num2(n_n2), .num3(n_n3), .num_rdy(n_rdy),
        .ent1(n_e1), .ent2(n_e2), .ent3(n_e3), .entry_cnt(n_cnt),
        .err(n_err), .guess_cnt(n_gc)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 mirrors dut_d (distinct), index 1 mirrors dut_n
    int q [2][$];
    bit m_chk  [2];
    bit m_iss  [2];
    int m_errl [2];
    int m_num  [2][3];
    bit m_rdy  [2];
    int m_gc   [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit kv, input logic [4:0] c);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                q[m].delete();
                m_chk[m] = 0; m_iss[m] = 0; m_errl[m] = 0; m_rdy[m] = 0; m_gc[m] = 0;
                for (int i = 0; i < 3; i++) m_num[m][i] = 0;
            end else begin
                m_rdy[m] = 0;
                if (m_chk[m]) begin
                    m_chk[m] = 0;
                    if (m == 0 && (q[m][0] == q[m][1] || q[m][0] == q[m][2] || q[m][1] == q[m][2])) begin
                        m_errl[m] = ERR;
                    end else begin
                        for (int i = 0; i < 3; i++) m_num[m][i] = q[m][i];
                        q[m].delete();
                        m_rdy[m] = 1;
                        m_iss[m] = 1;
                        if (m_gc[m] < 255) m_gc[m]++;
                    end
                end else if (m_iss[m]) begin
                    m_iss[m] = 0;
                end else if (m_errl[m] > 0) begin
                    m_errl[m]--;
                end else if (kv) begin
                    if (c <= 5'd9) begin
                        if (q[m].size() < 3) q[m].push_back(int'(c));
                    end else if (c == 5'h10) begin
                        if (q[m].size() == 3) m_chk[m] = 1;
                        else m_errl[m] = ERR;
                    end else if (c == 5'h11) begin
                        if (q[m].size() > 0) void'(q[m].pop_back());
                    end else if (c == 5'h12) begin
                        q[m].delete();
                    end
                end
            end
        end
    endtask

    function automatic logic [35:0] model_vec(input int m);
        logic [3:0] e [3];
        for (int i = 0; i < 3; i++) e[i] = (i < q[m].size()) ? 4'(q[m][i]) : 4'd0;
        return {4'(m_num[m][0]), 4'(m_num[m][1]), 4'(m_num[m][2]), m_rdy[m],
                e[0], e[1], e[2], 2'(q[m].size()), (m_errl[m] > 0), 8'(m_gc[m])};
    endfunction

    task automatic tick(input bit r, input bit kv, input logic [4:0] c);
        reset = r; key_valid = kv; key_code = c;
        @(posedge clk);
        model_step(r, kv, c);
        #1;
        chk("model_distinct", {28'd0, d_n1, d_n2, d_n3, d_rdy, d_e1, d_e2, d_e3, d_cnt, d_err, d_gc},
            {28'd0, model_vec(0)});
        chk("model_nodistinct", {28'd0, n_n1, n_n2, n_n3, n_rdy, n_e1, n_e2, n_e3, n_cnt, n_err, n_gc},
            {28'd0, model_vec(1)});
    endtask

    typedef struct {
        bit         rst;
        bit         kv;
        logic [4:0] code;
        bit         rdy;
        logic [1:0] cnt;
        logic [11:0] e;
        logic [11:0] n;
        logic [7:0] g;
    } vec_t;

    vec_t vt [26];
    int   errc;

    initial begin
        vt[0]  = '{1, 0, 5'h00, 0, 2'd0, 12'h000, 12'h000, 8'd0};
        vt[1]  = '{0, 1, 5'h01, 0, 2'd1, 12'h100, 12'h000, 8'd0};
        vt[2]  = '{0, 1, 5'h02, 0, 2'd2, 12'h120, 12'h000, 8'd0};
        vt[3]  = '{0, 1, 5'h03, 0, 2'd3, 12'h123, 12'h000, 8'd0};
        vt[4]  = '{0, 1, 5'h10, 0, 2'd3, 12'h123, 12'h000, 8'd0};
        vt[5]  = '{0, 0, 5'h00, 1, 2'd0, 12'h000, 12'h123, 8'd1};
        vt[6]  = '{0, 1, 5'h05, 0, 2'd0, 12'h000, 12'h123, 8'd1};
        vt[7]  = '{0, 1, 5'h01, 0, 2'd1, 12'h100, 12'h123, 8'd1};
        vt[8]  = '{0, 1, 5'h02, 0, 2'd2, 12'h120, 12'h123, 8'd1};
        vt[9]  = '{0, 1, 5'h03, 0, 2'd3, 12'h123, 12'h123, 8'd1};
        vt[10] = '{0, 1, 5'h11, 0, 2'd2, 12'h120, 12'h123, 8'd1};
        vt[11] = '{0, 1, 5'h06, 0, 2'd3, 12'h126, 12'h123, 8'd1};
        vt[12] = '{0, 1, 5'h09, 0, 2'd3, 12'h126, 12'h123, 8'd1};
        vt[13] = '{0, 1, 5'h10, 0, 2'd3, 12'h126, 12'h123, 8'd1};
        vt[14] = '{0, 0, 5'h00, 1, 2'd0, 12'h000, 12'h126, 8'd2};
        vt[15] = '{0, 1, 5'h11, 0, 2'd0, 12'h000, 12'h126, 8'd2};
        vt[16] = '{0, 1, 5'h0A, 0, 2'd0, 12'h000, 12'h126, 8'd2};
        vt[17] = '{0, 1, 5'h13, 0, 2'd0, 12'h000, 12'h126, 8'd2};
        vt[18] = '{0, 1, 5'h04, 0, 2'd1, 12'h400, 12'h126, 8'd2};
        vt[19] = '{0, 1, 5'h04, 0, 2'd2, 12'h440, 12'h126, 8'd2};
        vt[20] = '{0, 1, 5'h12, 0, 2'd0, 12'h000, 12'h126, 8'd2};
        vt[21] = '{0, 1, 5'h05, 0, 2'd1, 12'h500, 12'h126, 8'd2};
        vt[22] = '{0, 1, 5'h06, 0, 2'd2, 12'h560, 12'h126, 8'd2};
        vt[23] = '{0, 1, 5'h07, 0, 2'd3, 12'h567, 12'h126, 8'd2};
        vt[24] = '{0, 1, 5'h10, 0, 2'd3, 12'h567, 12'h126, 8'd2};
        vt[25] = '{1, 0, 5'h00, 0, 2'd0, 12'h000, 12'h000, 8'd0};

        for (int i = 0; i < 26; i++) begin
            tick(vt[i].rst, vt[i].kv, vt[i].code);
            chk($sformatf("vec%0d", i),
                {28'd0, d_rdy, d_cnt, d_e1, d_e2, d_e3, d_n1, d_n2, d_n3, d_gc, d_err},
                {28'd0, vt[i].rdy, vt[i].cnt, vt[i].e, vt[i].n, vt[i].g, 1'b0});
        end

        // Repeated digits: distinct build errors, non-distinct build issues
        tick(1, 0, 0);
        tick(0, 1, 5'h04); tick(0, 1, 5'h04); tick(0, 1, 5'h05); tick(0, 1, 5'h10);
        tick(0, 0, 0);
        chk("t2_n_rdy", {63'd0, n_rdy}, 64'd1);
        chk("t2_n_num", {52'd0, n_n1, n_n2, n_n3}, {52'd0, 12'h445});
        chk("t2_d_rdy", {63'd0, d_rdy}, 64'd0);
        errc = 0;
        for (int i = 0; i < 30 && d_err; i++) begin
            errc++;
            tick(0, 0, 0);
        end
        chk("t2_err_len", 64'(errc), 64'(ERR));
        chk("t2_ent_kept", {50'd0, d_e1, d_e2, d_e3, d_cnt}, {50'd0, 12'h445, 2'd3});

        // Short entry, edit after error window, then complete
        tick(1, 0, 0);
        tick(0, 1, 5'h07); tick(0, 1, 5'h08); tick(0, 1, 5'h10);
        chk("t3_err", {63'd0, d_err}, 64'd1);
        for (int i = 0; i < 30 && d_err; i++) tick(0, 1, (i % 2) ? 5'h13 : 5'h01);
        chk("t3_err_done", {63'd0, d_err}, 64'd0);
        chk("t3_cnt_kept", {62'd0, d_cnt}, 64'd2);
        tick(0, 1, 5'h09); tick(0, 1, 5'h10); tick(0, 0, 0);
        chk("t3_d_num", {51'd0, d_rdy, d_n1, d_n2, d_n3}, {51'd0, 1'b1, 12'h789});
        chk("t3_n_num", {51'd0, n_rdy, n_n1, n_n2, n_n3}, {51'd0, 1'b1, 12'h789});
        tick(0, 0, 0);
        chk("t3_rdy_one_cycle", {63'd0, d_rdy}, 64'd0);

        // Saturation of the guess counter
        tick(1, 0, 0);
        for (int g = 0; g < 256; g++) begin
            tick(0, 1, 5'h01); tick(0, 1, 5'h02); tick(0, 1, 5'h03); tick(0, 1, 5'h10);
            tick(0, 0, 0); tick(0, 0, 0);
        end
        chk("t6_d_gcnt", {56'd0, d_gc}, 64'd255);
        chk("t6_n_gcnt", {56'd0, n_gc}, 64'd255);

        // Random key traffic against the model
        tick(1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [4:0] c;
            sel = $urandom_range(0, 19);
            if (sel < 10)      c = 5'(sel);
            else if (sel < 13) c = 5'h10;
            else if (sel < 15) c = 5'h11;
            else if (sel < 16) c = 5'h12;
            else               c = 5'($urandom_range(0, 31));
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
